coin_input_conditioner: RTL and testbench

//  Upstream stage of the Vending_Machine that sits between the raw coin-slot sensors and the

---
 rtl/coin_input_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: sync, debounce, queue and serialise coin events
// into clean one-hot credit pulses for the vending FSM.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic quarter_raw,
  input  logic dime_raw,
  input  logic nickel_raw,
  input  logic inhibit,
  output logic quarter,
  output logic dime,
  output logic nickel,
  output logic queue_empty,
  output logic overflow_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(QUEUE_DEPTH);

  typedef logic [1:0] coin_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [2:0] raw;
  logic [2:0] rise;
  logic [1:0] warm;

  assign raw = {nickel_raw, dime_raw, quarter_raw};

  // warm[1] marks that the synchronisers hold real samples again after reset
  always_ff @(posedge clk) begin
    if (rst) warm <= '0;
    else     warm <= {warm[0], 1'b1};
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          deb;
    logic          armed;
    logic          rise_q;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          done;

    assign differ  = s2 != deb;
    assign done    = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise[i] = rise_q;

    // two-flop synchroniser for the asynchronous sensor level
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
      end
    end

    // debounce counter; a rising flip is an event only once the
    // sensor has been seen low since reset
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        deb    <= 1'b0;
        armed  <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        rise_q <= done && s2 && armed;
        if (!differ) begin
          cnt <= '0;
        end else if (done) begin
          cnt <= '0;
          deb <= s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (warm[1] && !s2) armed <= 1'b1;
      end
    end
  end

  coin_t        mem [QUEUE_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  used;
  logic [AW:0]  free;
  logic         empty;
  logic [1:0]   n_push;
  logic [2:0]   wv;
  coin_t        wc [3];
  logic         drop;
  logic         pop;
  coin_t        head;
  state_t       state;
  state_t       next;
  logic [2:0]   coins;

  assign used  = wr_ptr - rd_ptr;
  assign free  = (AW+1)'(QUEUE_DEPTH) - used;
  assign empty = wr_ptr == rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // pack this cycle's events in quarter, dime, nickel order into free slots
  always_comb begin
    n_push = '0;
    wv     = '0;
    drop   = 1'b0;
    for (int k = 0; k < 3; k++) wc[k] = '0;
    for (int i = 0; i < 3; i++) begin
      if (rise[i]) begin
        if (free > (AW+1)'(n_push)) begin
          wv[n_push] = 1'b1;
          wc[n_push] = coin_t'(i);
          n_push     = n_push + 2'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // queue storage writes
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wv[k]) mem[wr_ptr[AW-1:0] + AW'(k)] <= wc[k];
    end
  end

  // queue pointers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(n_push);
      if (pop)  rd_ptr       <= rd_ptr + (AW+1)'(1);
      if (drop) overflow_err <= 1'b1;
    end
  end

  // output FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // output FSM next state and pop decision
  always_comb begin
    next = state;
    pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !inhibit) begin
          pop  = 1'b1;
          next = EMIT;
        end
      end
      EMIT:    next = GAP;
      GAP:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // registered one-hot credit pulse
  always_ff @(posedge clk) begin
    if (rst)      coins <= '0;
    else if (pop) coins <= 3'b001 << head;
    else          coins <= '0;
  end

  assign quarter     = coins[0];
  assign dime        = coins[1];
  assign nickel      = coins[2];
  assign queue_empty = empty;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench for coin_input_conditioner: directed spec scenarios
// plus random sensor activity against a behavioural reference model.
module tb_coin_input_conditioner;

  localparam int D  = 4;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic quarter_raw = 1'b0;
  logic dime_raw = 1'b0;
  logic nickel_raw = 1'b0;
  logic inhibit = 1'b0;
  logic quarter, dime, nickel, queue_empty, overflow_err;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .quarter_raw(quarter_raw),
    .dime_raw(dime_raw),
    .nickel_raw(nickel_raw),
    .inhibit(inhibit),
    .quarter(quarter),
    .dime(dime),
    .nickel(nickel),
    .queue_empty(queue_empty),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coin;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   m_q[$];
  int   cyc = 0;
  bit   started = 0;
  bit   m_ovf = 0;
  int   last_pop = -100;
  int   m_warm = 0;
  bit   m_s1[3], m_s2[3], m_deb[3], m_arm[3], m_rise[3];
  int   m_run[3];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  // reference model: a coin is credited when its sensor has been seen
  // (through a 2-sample delay) differing for D samples in a row, one
  // cycle later it queues; pulses need queue, no inhibit, >=3 cycle spacing
  always @(posedge clk) begin
    bit r[3];
    r = '{quarter_raw, dime_raw, nickel_raw};
    cyc++;
    if (rst) begin
      started = 1;
      m_q.delete();
      m_ovf = 0;
      last_pop = -100;
      m_warm = 0;
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0;
        m_arm[c] = 0; m_rise[c] = 0; m_run[c] = 0;
      end
    end else begin
      int sz;
      int fr;
      sz = m_q.size();
      if (cyc - last_pop >= 3 && sz > 0 && !inhibit) begin
        exp_t e;
        e.coin = m_q.pop_front();
        e.cyc = cyc;
        sb.push_back(e);
        last_pop = cyc;
      end
      fr = QD - sz;
      for (int c = 0; c < 3; c++) begin
        if (m_rise[c]) begin
          if (fr > 0) begin
            m_q.push_back(c);
            fr--;
          end else begin
            m_ovf = 1;
          end
        end
      end
      for (int c = 0; c < 3; c++) begin
        bit s, nr;
        s = m_s2[c];
        nr = 0;
        if (s == m_deb[c]) m_run[c] = 0;
        else if (m_run[c] == D - 1) begin
          m_deb[c] = s;
          m_run[c] = 0;
          nr = s && m_arm[c];
        end else m_run[c]++;
        if (m_warm >= 2 && !s) m_arm[c] = 1;
        m_rise[c] = nr;
        m_s2[c] = m_s1[c];
        m_s1[c] = r[c];
      end
      if (m_warm < 2) m_warm++;
    end
  end

  // monitor: compare pulses against scoreboard, flags against model
  always @(negedge clk) begin
    if (started) begin
      logic [2:0] exp_p, got;
      exp_p = 3'b000;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        exp_t s;
        s = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing: coin %0d due cycle %0d not seen", s.coin, s.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t s;
        s = sb.pop_front();
        exp_p = 3'b001 << s.coin;
      end
      got = {nickel, dime, quarter};
      if (got != 3'b000) pulses++;
      vectors++;
      if (got != exp_p) begin
        miscompares++;
        $display("FAIL pulse cycle %0d: got %b expected %b", cyc, got, exp_p);
      end
      vectors++;
      if (queue_empty !== (m_q.size() == 0)) begin
        miscompares++;
        $display("FAIL queue_empty cycle %0d: got %b expected %b", cyc, queue_empty, m_q.size() == 0);
      end
      vectors++;
      if (overflow_err !== m_ovf) begin
        miscompares++;
        $display("FAIL overflow_err cycle %0d: got %b expected %b", cyc, overflow_err, m_ovf);
      end
    end
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(logic [2:0] v);
    quarter_raw = v[0];
    dime_raw = v[1];
    nickel_raw = v[2];
  endtask

  task automatic coin(logic [2:0] v, int hi, int lo);
    set_raw(v);
    wait_n(hi);
    set_raw(3'b000);
    wait_n(lo);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    wait_n(n);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    wait_n(3);
    rst = 1'b0;
    wait_n(5);
    p0 = pulses;
    coin(3'b001, 8, 20);
    vectors++;
    if (pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL single_quarter_count: got %0d expected 1", pulses - p0);
    end
    p0 = pulses;
    coin(3'b100, 3, 20);
    vectors++;
    if (pulses - p0 != 0) begin
      miscompares++;
      $display("FAIL glitch_count: got %0d expected 0", pulses - p0);
    end
    coin(3'b101, 8, 25);
    inhibit = 1'b1;
    coin(3'b010, 8, 10);
    wait_n(5);
    inhibit = 1'b0;
    wait_n(10);
    inhibit = 1'b1;
    coin(3'b001, 8, 8);
    coin(3'b010, 8, 8);
    coin(3'b100, 8, 8);
    coin(3'b001, 8, 8);
    coin(3'b010, 8, 8);
    coin(3'b100, 8, 8);
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got %b expected 1", overflow_err);
    end
    inhibit = 1'b0;
    wait_n(30);
    inhibit = 1'b1;
    coin(3'b001, 8, 8);
    coin(3'b010, 8, 8);
    do_reset(2);
    inhibit = 1'b0;
    wait_n(20);
    vectors++;
    if (overflow_err !== 1'b0 || queue_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_clear: got ovf=%b empty=%b expected 0/1", overflow_err, queue_empty);
    end
    set_raw(3'b001);
    wait_n(10);
    do_reset(2);
    wait_n(15);
    set_raw(3'b000);
    wait_n(10);
    coin(3'b001, 8, 20);
    for (int i = 0; i < 80; i++) begin
      set_raw(3'($urandom_range(0, 7)));
      inhibit = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 40) == 0) do_reset(2);
      wait_n($urandom_range(1, 12));
    end
    set_raw(3'b000);
    inhibit = 1'b0;
    wait_n(80);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
